mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage responder for the load/store controls carried out of the EX/MEM pipeline register. It consumes the registered read/write codes, address (ALU result) and store data, and runs one multi-cycle transaction per request on a word-wide, byte-enabled req/ack data-memory port. It aligns store data into byte lanes and sign- or zero-extends load data. BUSYWAIT stalls the whole pipeline until the access completes.

Parameters:
ADDR_WIDTH, 32, byte-address width; the memory port carries bits [ADDR_WIDTH-1:2].

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high
MEM_DATA_MEM_READ  in  4  bit3 = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
MEM_DATA_MEM_WRITE  in  3  bit2 = store enable; [1:0] = funct3[1:0] (00 SB, 01 SH, 10 SW)
MEM_ALU_OUT  in  32  byte address
MEM_REG_DATA2  in  32  store data, right-aligned
READ_DATA  out  32  extended load result, to MEM/WB
BUSYWAIT  out  1  pipeline stall
MISALIGNED  out  1  one-cycle pulse on an illegal access (see Optional Feature)
DMEM_REQ  out  1  memory request
DMEM_WE  out  1  1 = write
DMEM_ADDR  out  ADDR_WIDTH-2  word address
DMEM_BE  out  4  byte enables
DMEM_WDATA  out  32  lane-aligned store data
DMEM_RDATA  in  32  read word
DMEM_ACK  in  1  one-cycle completion

Behaviour:
- Reset: state IDLE. READ_DATA=0, DMEM_REQ=0, DMEM_WE=0, DMEM_ADDR=0, DMEM_BE=0, DMEM_WDATA=0, MISALIGNED=0. BUSYWAIT=0 because state is IDLE.
- RESET asserted mid-transaction returns to IDLE immediately. A late DMEM_ACK in IDLE is ignored.
- Request valid = MEM_DATA_MEM_READ[3] | MEM_DATA_MEM_WRITE[2].
- If both enables are set, the load wins and no store is performed.
- State IDLE:
  - BUSYWAIT = request valid. This is combinational, so the stall takes effect in the same cycle.
  - On a valid request the unit registers DMEM_ADDR = addr[ADDR_WIDTH-1:2], DMEM_WE, DMEM_BE, DMEM_WDATA, the funct3 and addr[1:0], then goes to REQ.
- State REQ:
  - DMEM_REQ=1 and BUSYWAIT=1.
  - DMEM_ADDR, DMEM_WE, DMEM_BE and DMEM_WDATA are held stable until DMEM_ACK.
  - On DMEM_ACK: DMEM_REQ drops at the next edge, READ_DATA is registered (loads only; stores leave READ_DATA unchanged), and the state goes to DONE.
- State DONE:
  - BUSYWAIT=0 for exactly one cycle, so the pipeline advances at the end of this cycle.
  - The request still on the inputs is the one just served and is ignored.
  - Next state is IDLE.
- Minimum stall: a 0-wait memory that acks in the first REQ cycle gives BUSYWAIT high for 2 cycles, then the DONE cycle. Each memory wait cycle adds 1.
- Store lane alignment, with b = addr[1:0]:
  - SB: BE = 0001<<b, WDATA = {4{data[7:0]}}.
  - SH: BE = 0011<<(2*addr[1]), WDATA = {2{data[15:0]}}.
  - SW: BE = 1111, WDATA = data.
- Load extraction:
  - LB/LBU: byte at lane b.
  - LH/LHU: halfword at lane addr[1].
  - LW: full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Undefined funct3 values (e.g. load 011/110/111, store 11): no access, treated as misaligned.

Optional Feature:
MEM_ALIGN_CHECK_EN:
- Defined: an access is misaligned when a halfword has addr[0]=1, or a word has addr[1:0]!=0.
  - A misaligned (or undefined) request pulses MISALIGNED for 1 cycle in IDLE and goes straight to DONE.
  - DMEM_REQ is never raised, READ_DATA is set to 0, and BUSYWAIT is high for 1 cycle.
- Undefined: MISALIGNED is tied to 0. Low address bits below the access size are ignored: the halfword uses lane addr[1], and the word is accessed at addr & ~3.

Decomposition:
- Shared package: localparams for the load/store funct3 codes, the enable bit positions, and the state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
- One natural combinational sub-module: mem_load_extend (rdata, funct3, addr[1:0] -> 32-bit extended result). The store lane alignment stays inline.

Test Plan:
- SW 0xDEADBEEF @0x104 with a memory acking on the 1st REQ cycle -> DMEM_ADDR=0x41, DMEM_BE=1111, DMEM_WE=1; BUSYWAIT high 2 cycles then low 1 cycle.
- SB 0x000000AB @0x103 -> DMEM_BE=1000, DMEM_WDATA=0xABABABAB.
- Memory word 0x80F0_7F01: LB @0x2 -> 0xFFFFFFF0; LBU @0x2 -> 0x000000F0; LH @0x2 -> 0xFFFF80F0; LHU @0x0 -> 0x00007F01.
- LW with DMEM_ACK delayed 5 cycles -> DMEM_REQ and address held stable for 5 cycles; BUSYWAIT high 6 cycles; READ_DATA valid in the DONE cycle.
- RESET in REQ, then a stray DMEM_ACK -> IDLE, DMEM_REQ=0, READ_DATA=0, no state change.
- With MEM_ALIGN_CHECK_EN, LW @0x102 -> MISALIGNED pulse, DMEM_REQ never asserted, BUSYWAIT high 1 cycle, READ_DATA=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: funct3 codes,
// enable bit positions in the EX/MEM control fields, FSM encoding and
// funct3 legality helpers.
package mem_access_unit_pkg;

    // Enable bits inside MEM_DATA_MEM_READ / MEM_DATA_MEM_WRITE
    localparam int LOAD_EN_BIT  = 3;
    localparam int STORE_EN_BIT = 2;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3[1:0] codes
    localparam logic [1:0] SF_SB = 2'b00;
    localparam logic [1:0] SF_SH = 2'b01;
    localparam logic [1:0] SF_SW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: load_f3_ok = 1'b1;
            default:                             load_f3_ok = 1'b0;
        endcase
    endfunction

    function automatic logic store_f3_ok(input logic [1:0] f3);
        case (f3)
            SF_SB, SF_SH, SF_SW: store_f3_ok = 1'b1;
            default:             store_f3_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data extraction: picks the byte/halfword lane out of the read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports: i_rdata (memory word), i_funct3 (load type), i_addr_lo (addr[1:0]),
//        o_result (extended load value; 0 for undefined funct3).
module mem_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfword lane follows addr[1] only; addr[0] is ignored here.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LW:   o_result = i_rdata;
            F3_LBU:  o_result = {24'd0, w_byte};
            F3_LHU:  o_result = {16'd0, w_half};
            default: o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one req/ack transaction per request on a
// word-wide byte-enabled data memory port, BUSYWAIT stalls the pipeline.
// Ports: CLK/RESET (sync, active-high); EX/MEM controls MEM_DATA_MEM_READ,
//        MEM_DATA_MEM_WRITE, MEM_ALU_OUT, MEM_REG_DATA2; READ_DATA, BUSYWAIT,
//        MISALIGNED to the pipeline; DMEM_* to the data memory.
// Build option: define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word
// accesses (MISALIGNED pulse, no memory access); otherwise MISALIGNED is 0.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            MEM_DATA_MEM_READ,
    input  logic [2:0]            MEM_DATA_MEM_WRITE,
    input  logic [31:0]           MEM_ALU_OUT,
    input  logic [31:0]           MEM_REG_DATA2,
    output logic [31:0]           READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  MISALIGNED,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic [ADDR_WIDTH-3:0] DMEM_ADDR,
    output logic [3:0]            DMEM_BE,
    output logic [31:0]           DMEM_WDATA,
    input  logic [31:0]           DMEM_RDATA,
    input  logic                  DMEM_ACK
);

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic [31:0]           r_read_data;

    logic                  w_req_vld;
    logic                  w_is_load;
    logic                  w_bad_f3;
    logic                  w_misal;
    logic                  w_skip;
    logic [3:0]            w_st_be;
    logic [31:0]           w_st_wdata;
    logic [31:0]           w_ext;

    // Request decode; a load wins when both enables are set.
    always_comb begin
        w_req_vld = MEM_DATA_MEM_READ[LOAD_EN_BIT] | MEM_DATA_MEM_WRITE[STORE_EN_BIT];
        w_is_load = MEM_DATA_MEM_READ[LOAD_EN_BIT];
        w_bad_f3  = w_is_load ? ~load_f3_ok(MEM_DATA_MEM_READ[2:0])
                              : ~store_f3_ok(MEM_DATA_MEM_WRITE[1:0]);
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] w_size;
    always_comb begin
        // Load and store funct3[1:0] share the size encoding (01 half, 10 word).
        w_size  = w_is_load ? MEM_DATA_MEM_READ[1:0] : MEM_DATA_MEM_WRITE[1:0];
        w_misal = ((w_size == 2'b01) && MEM_ALU_OUT[0]) ||
                  ((w_size == 2'b10) && (MEM_ALU_OUT[1:0] != 2'b00));
    end
    assign MISALIGNED = (r_state == ST_IDLE) && w_req_vld && w_skip;
`else
    assign w_misal    = 1'b0;
    assign MISALIGNED = 1'b0;
`endif

    assign w_skip = w_bad_f3 | w_misal;

    // Store lane alignment
    always_comb begin
        w_st_be    = 4'b0000;
        w_st_wdata = 32'd0;
        case (MEM_DATA_MEM_WRITE[1:0])
            SF_SB: begin
                w_st_be    = 4'b0001 << MEM_ALU_OUT[1:0];
                w_st_wdata = {4{MEM_REG_DATA2[7:0]}};
            end
            SF_SH: begin
                w_st_be    = 4'b0011 << {MEM_ALU_OUT[1], 1'b0};
                w_st_wdata = {2{MEM_REG_DATA2[15:0]}};
            end
            SF_SW: begin
                w_st_be    = 4'b1111;
                w_st_wdata = MEM_REG_DATA2;
            end
            default: ;
        endcase
    end

    mem_load_extend u_load_extend (
        .i_rdata   (DMEM_RDATA),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .o_result  (w_ext)
    );

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        BUSYWAIT     = 1'b0;
        DMEM_REQ     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Combinational stall so the pipeline freezes this cycle.
                BUSYWAIT = w_req_vld;
                if (w_req_vld) w_next_state = w_skip ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                BUSYWAIT = 1'b1;
                DMEM_REQ = 1'b1;
                if (DMEM_ACK) w_next_state = ST_DONE;
            end
            // Pipeline advances; the request still on the inputs is ignored.
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_wdata     <= 32'd0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_vld && !w_skip) begin
                        r_addr    <= MEM_ALU_OUT[ADDR_WIDTH-1:2];
                        r_we      <= ~w_is_load;
                        r_be      <= w_is_load ? 4'b1111 : w_st_be;
                        r_wdata   <= w_is_load ? 32'd0 : w_st_wdata;
                        r_funct3  <= w_is_load ? MEM_DATA_MEM_READ[2:0]
                                               : {1'b0, MEM_DATA_MEM_WRITE[1:0]};
                        r_addr_lo <= MEM_ALU_OUT[1:0];
                    end else if (w_req_vld) begin
                        r_read_data <= 32'd0;
                    end
                end
                ST_REQ: begin
                    if (DMEM_ACK && !r_we) r_read_data <= w_ext;
                end
                default: ;
            endcase
        end
    end

    assign READ_DATA  = r_read_data;
    assign DMEM_WE    = r_we;
    assign DMEM_ADDR  = r_addr;
    assign DMEM_BE    = r_be;
    assign DMEM_WDATA = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  MEM_DATA_MEM_READ = 4'd0;
    logic [2:0]  MEM_DATA_MEM_WRITE = 3'd0;
    logic [31:0] MEM_ALU_OUT = 32'd0;
    logic [31:0] MEM_REG_DATA2 = 32'd0;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [29:0] DMEM_ADDR;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_WDATA;
    logic [31:0] DMEM_RDATA = 32'd0;
    logic        DMEM_ACK = 1'b0;

    int checks = 0;
    int failures = 0;

    // Observations from one transaction
    int          obs_busy, obs_reqs, obs_mis;
    logic        obs_done, obs_stable, obs_we;
    logic [29:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_rd;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
        .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK)
    );

    always #5 CLK = ~CLK;

    // Drives one request and plays memory: ack on REQ cycle number ack_at.
    // Inputs are held through the DONE cycle, then cleared.
    task automatic run_txn(input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] mem, input int ack_at);
        obs_busy = 0; obs_reqs = 0; obs_mis = 0; obs_done = 1'b0; obs_stable = 1'b1;
        obs_addr = '0; obs_we = 1'b0; obs_be = 4'd0; obs_wdata = 32'd0; obs_rd = 32'd0;
        MEM_DATA_MEM_READ = rd; MEM_DATA_MEM_WRITE = wr;
        MEM_ALU_OUT = addr; MEM_REG_DATA2 = data; DMEM_RDATA = mem;
        for (int i = 0; i < 40 && !obs_done; i++) begin
            @(negedge CLK);
            if (MISALIGNED) obs_mis++;
            if (BUSYWAIT) begin
                obs_busy++;
                if (DMEM_REQ) begin
                    obs_reqs++;
                    if (obs_reqs == 1) begin
                        obs_addr = DMEM_ADDR; obs_we = DMEM_WE;
                        obs_be = DMEM_BE; obs_wdata = DMEM_WDATA;
                    end else if (DMEM_ADDR !== obs_addr || DMEM_WE !== obs_we ||
                                 DMEM_BE !== obs_be || DMEM_WDATA !== obs_wdata) begin
                        obs_stable = 1'b0;
                    end
                    if (obs_reqs == ack_at) DMEM_ACK = 1'b1;
                end
            end else begin
                obs_done = 1'b1;
                obs_rd = READ_DATA;
            end
            @(posedge CLK); #1;
            DMEM_ACK = 1'b0;
        end
        MEM_DATA_MEM_READ = 4'd0; MEM_DATA_MEM_WRITE = 3'd0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++; if (READ_DATA !== 32'd0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", READ_DATA); end
        checks++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
        checks++; if (DMEM_REQ !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", DMEM_REQ); end
        checks++; if (DMEM_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", DMEM_WE); end
        checks++; if (DMEM_ADDR !== 30'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", DMEM_ADDR); end
        checks++; if (DMEM_BE !== 4'd0 || DMEM_WDATA !== 32'd0) begin failures++; $display("FAIL reset_be_wdata got=%b/%h exp=0/0", DMEM_BE, DMEM_WDATA); end
        checks++; if (MISALIGNED !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", MISALIGNED); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_store_word();
        run_txn(4'b0000, 3'b110, 32'h104, 32'hDEADBEEF, 32'd0, 1);
        checks++; if (obs_done !== 1'b1) begin failures++; $display("FAIL sw_done got=%b exp=1", obs_done); end
        checks++; if (obs_addr !== 30'h41) begin failures++; $display("FAIL sw_addr got=%h exp=41", obs_addr); end
        checks++; if (obs_be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", obs_be); end
        checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL sw_we got=%b exp=1", obs_we); end
        checks++; if (obs_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", obs_wdata); end
        checks++; if (obs_busy != 2) begin failures++; $display("FAIL sw_busy_cycles got=%0d exp=2", obs_busy); end
        checks++; if (obs_reqs != 1) begin failures++; $display("FAIL sw_req_cycles got=%0d exp=1", obs_reqs); end
        @(negedge CLK);
        checks++; if (DMEM_REQ !== 1'b0 || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL sw_idle_after got=%b%b exp=00", DMEM_REQ, BUSYWAIT); end
        @(posedge CLK); #1;
    endtask

    task automatic test_store_lanes();
        run_txn(4'b0000, 3'b100, 32'h103, 32'h000000AB, 32'd0, 1);
        checks++; if (obs_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", obs_be); end
        checks++; if (obs_wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", obs_wdata); end
        run_txn(4'b0000, 3'b101, 32'h102, 32'hFFFF1234, 32'd0, 2);
        checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
        checks++; if (obs_wdata !== 32'h12341234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", obs_wdata); end
        checks++; if (obs_busy != 3) begin failures++; $display("FAIL sh_busy_cycles got=%0d exp=3", obs_busy); end
    endtask

    task automatic test_load_extend();
        logic [3:0]  rd_v  [6] = '{4'b1000, 4'b1100, 4'b1001, 4'b1101, 4'b1010, 4'b1000};
        logic [31:0] adr_v [6] = '{32'h2, 32'h2, 32'h2, 32'h0, 32'h0, 32'h1};
        logic [31:0] exp_v [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0,
                                   32'h00007F01, 32'h80F07F01, 32'h0000007F};
        for (int k = 0; k < 6; k++) begin
            run_txn(rd_v[k], 3'b000, adr_v[k], 32'd0, 32'h80F07F01, 1);
            checks++; if (obs_rd !== exp_v[k]) begin failures++; $display("FAIL load_ext_%0d got=%h exp=%h", k, obs_rd, exp_v[k]); end
        end
        checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL load_we got=%b exp=0", obs_we); end
    endtask

    task automatic test_store_keeps_rdata();
        run_txn(4'b0000, 3'b110, 32'h20, 32'h11111111, 32'h99999999, 1);
        checks++; if (READ_DATA !== 32'h0000007F) begin failures++; $display("FAIL store_keeps_rd got=%h exp=0000007f", READ_DATA); end
    endtask

    task automatic test_wait_states();
        run_txn(4'b1010, 3'b000, 32'h200, 32'd0, 32'h12345678, 5);
        checks++; if (obs_reqs != 5) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=5", obs_reqs); end
        checks++; if (obs_busy != 6) begin failures++; $display("FAIL wait_busy_cycles got=%0d exp=6", obs_busy); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL wait_stable got=%b exp=1", obs_stable); end
        checks++; if (obs_addr !== 30'h80) begin failures++; $display("FAIL wait_addr got=%h exp=80", obs_addr); end
        checks++; if (obs_rd !== 32'h12345678) begin failures++; $display("FAIL wait_rd_done got=%h exp=12345678", obs_rd); end
    endtask

    task automatic test_reset_mid();
        MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h300; DMEM_RDATA = 32'h5555AAAA;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (DMEM_REQ !== 1'b1) begin failures++; $display("FAIL rst_mid_in_req got=%b exp=1", DMEM_REQ); end
        @(posedge CLK); #1;
        RESET = 1'b1; MEM_DATA_MEM_READ = 4'd0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (DMEM_REQ !== 1'b0 || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b%b exp=00", DMEM_REQ, BUSYWAIT); end
        checks++; if (READ_DATA !== 32'd0 || DMEM_ADDR !== 30'd0) begin failures++; $display("FAIL rst_mid_regs got=%h/%h exp=0/0", READ_DATA, DMEM_ADDR); end
        DMEM_ACK = 1'b1;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        checks++; if (DMEM_REQ !== 1'b0 || BUSYWAIT !== 1'b0 || READ_DATA !== 32'd0) begin failures++; $display("FAIL stray_ack got=%b%b/%h exp=00/0", DMEM_REQ, BUSYWAIT, READ_DATA); end
        @(posedge CLK); #1;
    endtask

    task automatic test_both_enables();
        run_txn(4'b1010, 3'b110, 32'h8, 32'h77777777, 32'hCAFEF00D, 1);
        checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL both_we got=%b exp=0", obs_we); end
        checks++; if (obs_rd !== 32'hCAFEF00D) begin failures++; $display("FAIL both_rd got=%h exp=cafef00d", obs_rd); end
    endtask

    task automatic test_undefined();
        int exp_mis;
`ifdef MEM_ALIGN_CHECK_EN
        exp_mis = 1;
`else
        exp_mis = 0;
`endif
        run_txn(4'b1011, 3'b000, 32'h10, 32'd0, 32'hFFFFFFFF, 1);
        checks++; if (obs_reqs != 0) begin failures++; $display("FAIL undef_ld_req got=%0d exp=0", obs_reqs); end
        checks++; if (obs_busy != 1) begin failures++; $display("FAIL undef_ld_busy got=%0d exp=1", obs_busy); end
        checks++; if (obs_rd !== 32'd0) begin failures++; $display("FAIL undef_ld_rd got=%h exp=0", obs_rd); end
        checks++; if (obs_mis != exp_mis) begin failures++; $display("FAIL undef_ld_mis got=%0d exp=%0d", obs_mis, exp_mis); end
        run_txn(4'b0000, 3'b111, 32'h10, 32'h1, 32'd0, 1);
        checks++; if (obs_reqs != 0 || obs_busy != 1) begin failures++; $display("FAIL undef_st got=%0d/%0d exp=0/1", obs_reqs, obs_busy); end
    endtask

    task automatic test_misaligned();
        run_txn(4'b1010, 3'b000, 32'h102, 32'd0, 32'h0BADF00D, 1);
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (obs_mis != 1) begin failures++; $display("FAIL misal_pulse got=%0d exp=1", obs_mis); end
        checks++; if (obs_reqs != 0) begin failures++; $display("FAIL misal_req got=%0d exp=0", obs_reqs); end
        checks++; if (obs_busy != 1) begin failures++; $display("FAIL misal_busy got=%0d exp=1", obs_busy); end
        checks++; if (obs_rd !== 32'd0) begin failures++; $display("FAIL misal_rd got=%h exp=0", obs_rd); end
`else
        checks++; if (obs_mis != 0) begin failures++; $display("FAIL misal_pulse got=%0d exp=0", obs_mis); end
        checks++; if (obs_addr !== 30'h40 || obs_be !== 4'b1111) begin failures++; $display("FAIL misal_word got=%h/%b exp=40/1111", obs_addr, obs_be); end
        checks++; if (obs_busy != 2) begin failures++; $display("FAIL misal_busy got=%0d exp=2", obs_busy); end
        checks++; if (obs_rd !== 32'h0BADF00D) begin failures++; $display("FAIL misal_rd got=%h exp=0badf00d", obs_rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_extend();
        test_store_keeps_rdata();
        test_wait_states();
        test_reset_mid();
        test_both_enables();
        test_undefined();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
